// File: rtl/dport_pkg.sv
// Shared definitions for the debug port: register offsets, bit positions and default window base.
package dport_pkg;

    localparam int unsigned DPORT_DW = 8;

    typedef enum logic [1:0] {
        DPORT_STATUS = 2'd0,
        DPORT_DATA   = 2'd1,
        DPORT_CTRL   = 2'd2,
        DPORT_COUNT  = 2'd3
    } dport_reg_e;

    localparam int unsigned STATUS_NONEMPTY = 0;
    localparam int unsigned STATUS_FULL     = 1;

    localparam int unsigned CTRL_POP   = 0;
    localparam int unsigned CTRL_FLUSH = 1;

    localparam logic [15:0] DPORT_BASE_ADDR = 16'h4000;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head, occupancy count and a flush that keeps a same-cycle push.
module sync_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      head,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned AW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    wr_idx;
    logic             push_en;
    logic             pop_en;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty & ~flush;
    // A push alongside a flush lands in slot 0 so it becomes the new head.
    assign wr_idx  = flush ? '0 : wptr;
    assign head    = mem[rptr];

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_idx] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= push_en ? AW'(1) : '0;
            count <= push_en ? CW'(1) : '0;
        end else begin
            if (push_en) begin
                wptr <= wptr + AW'(1);
            end
            if (pop_en) begin
                rptr <= rptr + AW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dport_in.sv
// Memory-mapped input debug port: host bytes queue in a FIFO, the core reads status/data and pops via CTRL.
module dport_in
    import dport_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter logic [15:0] BASE_ADDR  = DPORT_BASE_ADDR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [15:0]         addr,
    input  logic                we,
    input  logic [DPORT_DW-1:0] data_in,
    output logic [DPORT_DW-1:0] data_out,
    output logic                cs,
    input  logic [DPORT_DW-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                nonempty
);

    logic [DPORT_DW-1:0] head;
    logic [DEPTH_LOG2:0] count;
    logic                full;
    logic                empty;
    logic                ctrl_wr;
    logic                pop;
    logic                flush;
    dport_reg_e          reg_off;
    logic [DPORT_DW-1:0] rd_data_c;
    wire                 unused_ctrl_bits = ^data_in[DPORT_DW-1:2];

    assign cs       = (addr[15:2] == BASE_ADDR[15:2]);
    assign reg_off  = dport_reg_e'(addr[1:0]);
    assign ctrl_wr  = cs & we & (reg_off == DPORT_CTRL);
    assign pop      = ctrl_wr & data_in[CTRL_POP];
    assign flush    = ctrl_wr & data_in[CTRL_FLUSH];
    assign in_ready = ~full;
    assign nonempty = ~empty;

    sync_fifo #(
        .WIDTH      (DPORT_DW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (in_valid),
        .pop   (pop),
        .flush (flush),
        .din   (in_data),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Register read mux; reads never alter FIFO state.
    always_comb begin
        rd_data_c = '0;
        case (reg_off)
            DPORT_STATUS: begin
                rd_data_c[STATUS_NONEMPTY] = ~empty;
                rd_data_c[STATUS_FULL]     = full;
            end
            DPORT_DATA:  rd_data_c = empty ? '0 : head;
            DPORT_COUNT: rd_data_c = DPORT_DW'(count);
            default:     rd_data_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out <= '0;
        end else begin
            data_out <= (cs & ~we) ? rd_data_c : '0;
        end
    end

endmodule

// File: tb/tb_dport_in.sv
// Directed bench for dport_in: queue-based reference model checked every cycle plus literal read checks.
module tb_dport_in;

    localparam logic [15:0] BASE = 16'h4000;
    localparam int          DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic        we = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic        cs;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        nonempty;

    int vectors = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [7:0] q[$];
    logic [7:0] exp_dout = 8'h00;

    dport_in #(.DEPTH_LOG2(4), .BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .we       (we),
        .data_in  (data_in),
        .data_out (data_out),
        .cs       (cs),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .nonempty (nonempty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [1:0] off);
        case (off)
            2'd0: return {6'b0, 1'(q.size() == DEPTH), 1'(q.size() != 0)};
            2'd1: return (q.size() != 0) ? q[0] : 8'h00;
            2'd3: return 8'(q.size());
            default: return 8'h00;
        endcase
    endfunction

    // Reference model: the FIFO is a queue; read data is what the register window showed before the edge.
    always @(posedge clk or negedge rst) begin
        bit hit;
        bit do_push;
        bit ctrl;
        if (!rst) begin
            q.delete();
            exp_dout = 8'h00;
        end else begin
            hit = (addr[15:2] == BASE[15:2]);
            exp_dout = (hit && !we) ? model_read(addr[1:0]) : 8'h00;
            do_push = in_valid && (q.size() < DEPTH);
            ctrl = hit && we && (addr[1:0] == 2'd2);
            if (ctrl && data_in[1]) q.delete();
            else if (ctrl && data_in[0] && q.size() != 0) void'(q.pop_front());
            if (do_push) q.push_back(in_data);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model data_out", data_out, exp_dout);
            check("model in_ready", 8'(in_ready), 8'(q.size() < DEPTH));
            check("model nonempty", 8'(nonempty), 8'(q.size() != 0));
            check("model cs", 8'(cs), 8'(addr[15:2] == BASE[15:2]));
        end
    end

    // Apply one cycle of inputs (called at posedge+1), return just after the consuming edge with inputs idle.
    task automatic step(input logic [15:0] a, input logic w, input logic [7:0] d,
                        input logic v, input logic [7:0] b);
        addr = a; we = w; data_in = d; in_valid = v; in_data = b;
        @(posedge clk); #1;
        addr = 16'h0000; we = 1'b0; data_in = 8'h00; in_valid = 1'b0; in_data = 8'h00;
    endtask

    task automatic rd(input logic [1:0] off, input logic [7:0] exp, input string name);
        step(BASE + 16'(off), 1'b0, 8'h00, 1'b0, 8'h00);
        check(name, data_out, exp);
    endtask

    task automatic push(input logic [7:0] b);
        step(16'h0000, 1'b0, 8'h00, 1'b1, b);
    endtask

    task automatic ctrl(input logic [7:0] d);
        step(BASE + 16'd2, 1'b1, d, 1'b0, 8'h00);
    endtask

    initial begin
        #1 rst = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Reset state
        rd(2'd0, 8'h00, "reset STATUS");
        check("reset in_ready", 8'(in_ready), 8'h01);
        rd(2'd3, 8'h00, "reset COUNT");

        // Single byte, side-effect-free reads, pop
        push(8'hA5);
        rd(2'd1, 8'hA5, "single DATA");
        rd(2'd0, 8'h01, "single STATUS");
        rd(2'd1, 8'hA5, "peek again 1");
        rd(2'd1, 8'hA5, "peek again 2");
        ctrl(8'h01);
        check("after pop nonempty", 8'(nonempty), 8'h00);
        rd(2'd3, 8'h00, "after pop COUNT");

        // Fill, overflow attempt, wrap-around
        for (int i = 0; i < 16; i++) push(8'(i));
        check("full in_ready", 8'(in_ready), 8'h00);
        rd(2'd0, 8'h03, "full STATUS");
        for (int i = 0; i < 3; i++) push(8'hFF);
        rd(2'd3, 8'h10, "full COUNT");
        for (int i = 0; i < 4; i++) ctrl(8'h01);
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
        rd(2'd3, 8'h10, "refill COUNT");
        for (int i = 0; i < 16; i++) begin
            rd(2'd1, 8'h04 + 8'(i), "drain order");
            ctrl(8'h01);
        end
        rd(2'd0, 8'h00, "drained STATUS");

        // Simultaneous events
        for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
        step(BASE + 16'd2, 1'b1, 8'h01, 1'b1, 8'h60);
        rd(2'd3, 8'h05, "push+pop COUNT");
        rd(2'd1, 8'h51, "push+pop head");
        step(BASE + 16'd2, 1'b1, 8'h03, 1'b1, 8'h77);
        rd(2'd3, 8'h01, "flush+push COUNT");
        rd(2'd1, 8'h77, "flush+push DATA");
        ctrl(8'h01);
        ctrl(8'h01);
        rd(2'd3, 8'h00, "empty pop COUNT");

        // Address decode
        push(8'h33);
        addr = 16'h3FFF; #1;
        check("cs at 3FFF", 8'(cs), 8'h00);
        step(16'h3FFF, 1'b0, 8'h00, 1'b0, 8'h00);
        check("read 3FFF", data_out, 8'h00);
        addr = 16'h4004; #1;
        check("cs at 4004", 8'(cs), 8'h00);
        step(16'h4004, 1'b0, 8'h00, 1'b0, 8'h00);
        check("read 4004", data_out, 8'h00);
        step(16'h4001, 1'b1, 8'h03, 1'b0, 8'h00);
        step(16'h4006, 1'b1, 8'h03, 1'b0, 8'h00);
        rd(2'd3, 8'h01, "ignored write COUNT");
        rd(2'd1, 8'h33, "ignored write DATA");

        // Asynchronous reset mid-operation
        for (int i = 0; i < 6; i++) push(8'h90 + 8'(i));
        rd(2'd3, 8'h07, "pre-reset COUNT");
        rd(2'd0, 8'h01, "pre-reset STATUS");
        #2 rst = 1'b0;
        #1;
        check("async data_out", data_out, 8'h00);
        check("async in_ready", 8'(in_ready), 8'h01);
        check("async nonempty", 8'(nonempty), 8'h00);
        @(posedge clk); #1 rst = 1'b1;
        rd(2'd3, 8'h00, "post-reset COUNT");
        rd(2'd1, 8'h00, "post-reset DATA");

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
